// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed hex scan controller: one shared decoder, one-hot digit drive,
// per-slot blank window, double-buffered display word, leading-zero suppression.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lzs,
    output logic [3:0]              dec_nib,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    dp_out,
    output logic                    blank,
    output logic                    frame_done
);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] DIG_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        dig_q, dig_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d, shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d, shadow_dp_q, shadow_dp_d;
    logic                    pending_q, pending_d;
    logic                    lzs_q, lzs_d;

    logic [3:0]              nib_q, nib_d;
    logic [NUM_DIGITS-1:0]   den_q, den_d;
    logic                    dp_q, dp_d, blank_q, blank_d, fd_q, fd_d;

    logic                    slot_last, frame_end, slot_start, suppress, show;
    logic [NUM_DIGITS-1:0]   zero_above;

    assign slot_last  = (state_q != IDLE) && (div_q == DIV_LAST);
    assign frame_end  = slot_last && (dig_q == DIG_LAST);
    assign slot_start = en && ((state_q == IDLE) || slot_last);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        dig_d   = dig_q;
        if (!en) begin
            state_d = IDLE;
            div_d   = '0;
            dig_d   = '0;
        end else if ((state_q == IDLE) || slot_last) begin
            div_d   = '0;
            dig_d   = ((state_q == IDLE) || (dig_q == DIG_LAST)) ? '0 : dig_q + 1'b1;
            state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end else begin
            div_d   = div_q + 1'b1;
            state_d = (int'(div_d) < BLANK_CYCLES) ? BLANK : SHOW;
        end
    end

    // Shadow captures every load; active only changes in IDLE or at the frame boundary.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        pending_d   = pending_q;
        if (load) begin
            shadow_d    = data_in;
            shadow_dp_d = dp_in;
        end
        if (state_q == IDLE) begin
            if (load) begin
                active_d    = data_in;
                active_dp_d = dp_in;
                pending_d   = 1'b0;
            end
        end else begin
            if (load) pending_d = 1'b1;
            if (frame_end) begin
                if (load) begin
                    active_d    = data_in;
                    active_dp_d = dp_in;
                end else if (pending_q) begin
                    active_d    = shadow_q;
                    active_dp_d = shadow_dp_q;
                end
                pending_d = 1'b0;
            end
        end
        lzs_d = slot_start ? lzs : lzs_q;
    end

    // zero_above[i]: digit i and all digits above it are zero.
    always_comb begin
        zero_above = '0;
        zero_above[NUM_DIGITS-1] = (active_d[4*NUM_DIGITS-1 -: 4] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_above[i] = (active_d[4*i +: 4] == 4'd0) && zero_above[i+1];
        end
    end

    // Output registers are fed from next-state values so they line up with the state.
    always_comb begin
        suppress = lzs_d && (dig_d != '0) && zero_above[dig_d];
        show     = (state_d == SHOW) && !suppress;
        nib_d    = (state_d == IDLE) ? 4'd0 : active_d[4*dig_d +: 4];
        den_d    = show ? (NUM_DIGITS'(1) << dig_d) : '0;
        dp_d     = show ? active_dp_d[dig_d] : 1'b0;
        blank_d  = !show;
        fd_d     = (state_d != IDLE) && (div_d == DIV_LAST) && (dig_d == DIG_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            dig_q       <= '0;
            active_q    <= '0;
            active_dp_q <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pending_q   <= 1'b0;
            lzs_q       <= 1'b0;
            nib_q       <= 4'd0;
            den_q       <= '0;
            dp_q        <= 1'b0;
            blank_q     <= 1'b1;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            dig_q       <= dig_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
            lzs_q       <= lzs_d;
            nib_q       <= nib_d;
            den_q       <= den_d;
            dp_q        <= dp_d;
            blank_q     <= blank_d;
            fd_q        <= fd_d;
        end
    end

    assign dec_nib    = nib_q;
    assign digit_en   = den_q;
    assign dp_out     = dp_q;
    assign blank      = blank_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-level reference model feeds an expected-output
// queue; a negedge monitor pops and compares every cycle.
module tb_seg_scan_ctrl;
    localparam int N  = 4;
    localparam int R  = 8;
    localparam int B  = 2;
    localparam int FR = N * R;

    logic          clk = 1'b0;
    logic          rst, en, load, lzs;
    logic [15:0]   data_in;
    logic [3:0]    dp_in;
    logic [3:0]    dec_nib;
    logic [3:0]    digit_en;
    logic          dp_out, blank, frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in),
        .dp_in(dp_in), .lzs(lzs), .dec_nib(dec_nib), .digit_en(digit_en),
        .dp_out(dp_out), .blank(blank), .frame_done(frame_done)
    );

    int checks   = 0;
    int failures = 0;
    logic [10:0] exp_q[$];

    // Reference state: mt counts cycles since scanning started.
    bit          mrun = 0;
    int          mt = 0;
    logic [15:0] mact = '0, msh = '0;
    logic [3:0]  mact_dp = '0, msh_dp = '0;
    bit          mpend = 0, mlzs = 0, fb;

    function automatic logic [10:0] model_out();
        int idx, pos;
        bit supp, show;
        logic [3:0] nib;
        logic [3:0] den;
        if (!mrun) return {4'd0, 4'd0, 1'b0, 1'b1, 1'b0};
        idx  = (mt / R) % N;
        pos  = mt % R;
        nib  = 4'((mact >> (4 * idx)) & 16'h000F);
        supp = mlzs && (idx != 0) && ((mact >> (4 * idx)) == 16'd0);
        show = (pos >= B) && !supp;
        den  = show ? 4'(1 << idx) : 4'd0;
        return {nib, den, show ? mact_dp[idx] : 1'b0, !show, (pos == R - 1) && (idx == N - 1)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mrun = 0; mt = 0; mact = '0; msh = '0; mact_dp = '0; msh_dp = '0;
            mpend = 0; mlzs = 0;
        end else begin
            fb = mrun && (mt % FR == FR - 1);
            if (!mrun) begin
                if (load) begin
                    mact = data_in; mact_dp = dp_in; msh = data_in; msh_dp = dp_in; mpend = 0;
                end
            end else begin
                if (fb) begin
                    if (load) begin
                        mact = data_in; mact_dp = dp_in;
                    end else if (mpend) begin
                        mact = msh; mact_dp = msh_dp;
                    end
                end
                if (load) begin
                    msh = data_in; msh_dp = dp_in;
                end
                mpend = fb ? 0 : (load ? 1 : mpend);
            end
            if (!en) begin
                mrun = 0; mt = 0;
            end else if (!mrun) begin
                mrun = 1; mt = 0;
            end else begin
                mt++;
            end
            if (mrun && (mt % R == 0)) mlzs = lzs;
        end
        exp_q.push_back(model_out());
    end

    always @(negedge clk) begin
        logic [10:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {dec_nib, digit_en, dp_out, blank, frame_done};
            checks++;
            if (a !== e) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL outputs t=%0t mt=%0d got nib=%h en=%b dp=%b blank=%b fd=%b required nib=%h en=%b dp=%b blank=%b fd=%b",
                             $time, mt, a[10:7], a[6:3], a[2], a[1], a[0], e[10:7], e[6:3], e[2], e[1], e[0]);
            end
        end
    end

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++) w[4*i +: 4] = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom % 16);
        return w;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] w, input logic [3:0] d);
        data_in = w; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        int k;
        k = 0;
        while (!(mrun && (mt % FR == p)) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            failures++;
            $display("FAIL wait_phase p=%0d got timeout required phase reached", p);
        end
    endtask

    logic [15:0] lz_words[3];

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b1; lzs = 1'b0;
        data_in = 16'hBEEF; dp_in = 4'hF;
        cyc(3);
        load = 1'b0; rst = 1'b0;
        cyc(4);

        pulse_load(16'h1234, 4'b0100);
        en = 1'b1;
        cyc(70);

        lzs = 1'b1;
        lz_words[0] = 16'h0005; lz_words[1] = 16'h0000; lz_words[2] = 16'h0405;
        for (int i = 0; i < 3; i++) begin
            pulse_load(lz_words[i], 4'b1111);
            cyc(70);
        end
        lzs = 1'b0;

        pulse_load(16'h1234, 4'b0001);
        cyc(40);
        wait_phase(10);
        pulse_load(16'hABCD, 4'b0010);
        cyc(40);
        wait_phase(FR - 1);
        pulse_load(16'h5678, 4'b1000);
        cyc(40);

        wait_phase(20);
        en = 1'b0;
        cyc(5);
        en = 1'b1;
        cyc(40);

        wait_phase(13);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc(40);

        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom % 400 == 0);
            en      = ($urandom % 150 == 0) ? ~en : en;
            load    = ($urandom % 20 == 0);
            data_in = rand_word();
            dp_in   = 4'($urandom);
            lzs     = ($urandom % 60 == 0) ? ~lzs : lzs;
            @(negedge clk);
        end
        rst = 1'b0; load = 1'b0;
        cyc(3);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got %0d entries required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
